// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial sequencer driving an external full adder, LSB first, into a parallel sum
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic carry_q;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  // next state and adder drive; the adder only sees operand bits while shifting
  always_comb begin
    state_n = state;
    busy    = state != IDLE;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_cin  = 1'b0;
    if (state == IDLE && start) state_n = SHIFT;
    if (state == SHIFT) begin
      fa_a    = a_sr[0];
      fa_b    = b_sr[0];
      fa_cin  = carry_q;
      state_n = last ? FIN : SHIFT;
    end
    if (state == FIN) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // operand capture, serial shifting and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= state == SHIFT && last;
      if (state == IDLE && start) begin
        a_sr    <= a;
        b_sr    <= b;
        carry_q <= cin;
        cnt     <= '0;
      end
      if (state == SHIFT) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        s_sr    <= {fa_s, s_sr[WIDTH-1:1]};
        carry_q <= fa_cout;
        cnt     <= last ? cnt : cnt + 1'b1;
        if (last) begin
          sum  <= {fa_s, s_sr[WIDTH-1:1]};
          cout <= fa_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench with a per-cycle arithmetic reference model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic fa_a, fa_b, fa_cin, fa_s, fa_cout, busy, done, cout;
  int pass_cnt = 0, total = 0, done_cnt = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  // external full adder
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    else pass_cnt++;
  endtask

  // reference model: ph = 0 idle, 1..W = serial step ph-1, W+1 = completion cycle
  int ph = 0;
  logic [W-1:0] ma, mb, m_sum = '0;
  logic mc, m_cout = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; m_sum = '0; m_cout = 0;
    end else if (ph == 0) begin
      if (start) begin ma = a; mb = b; mc = cin; ph = 1; end
    end else if (ph == W) begin
      {m_cout, m_sum} = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      ph = W + 1;
    end else if (ph == W + 1) ph = 0;
    else ph++;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [W:0] low;
    logic ea, eb, ec;
    int i;
    ea = 0; eb = 0; ec = 0;
    if (ph >= 1 && ph <= W) begin
      i = ph - 1;
      low = ({1'b0, ma} & ((9'd1 << i) - 9'd1)) + ({1'b0, mb} & ((9'd1 << i) - 9'd1)) + {{W{1'b0}}, mc};
      ea = ma[i]; eb = mb[i]; ec = low[i];
    end
    chk("busy", busy, ph != 0);
    chk("done", done, ph == W + 1);
    chk("sum", sum, m_sum);
    chk("cout", cout, m_cout);
    chk("fa_a", fa_a, ea);
    chk("fa_b", fa_b, eb);
    chk("fa_cin", fa_cin, ec);
    if (done) done_cnt++;
  end

  // issue one operation; optionally disturb start/a/b mid-shift; check literal result and timing
  task automatic run_op(input string n, input logic [W-1:0] xa, xb, input logic xc,
                        input logic [W-1:0] es, input logic ec, input bit disturb);
    int nb, saw;
    @(negedge clk); a = xa; b = xb; cin = xc; start = 1;
    @(negedge clk); start = 0;
    nb = 0; saw = 0;
    for (int i = 0; i < 30 && (nb == 0 || busy); i++) begin
      if (disturb && i == 3) begin start = 1; a = 8'h11; b = 8'h22; cin = ~xc; end
      if (disturb && i == 4) start = 0;
      if (busy) nb++;
      if (done) begin
        saw++;
        chk({n, "_sum"}, sum, es);
        chk({n, "_cout"}, cout, ec);
      end
      @(negedge clk);
    end
    chk({n, "_busy_cycles"}, nb, W + 1);
    chk({n, "_done_pulses"}, saw, 1);
  endtask

  initial begin
    int d0;
    #12;
    chk("reset_sum", sum, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_fa", {fa_a, fa_b, fa_cin}, 0);
    run_op("t1", 8'h3C, 8'h55, 0, 8'h91, 0, 0);
    run_op("t2a", 8'hFF, 8'h01, 0, 8'h00, 1, 0);
    @(negedge clk); a = 8'hFF; b = 8'hFF; cin = 1; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    chk("t2_hold_sum", sum, 8'h00);
    chk("t2_hold_cout", cout, 1);
    repeat (10) @(negedge clk);
    chk("t2b_sum", sum, 8'hFF);
    chk("t2b_cout", cout, 1);
    d0 = done_cnt;
    @(negedge clk); a = 8'h0F; b = 8'h01; cin = 0; start = 1;
    repeat (20) @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    chk("hold_start_dones", done_cnt - d0, 2);
    chk("hold_start_sum", sum, 8'h10);
    chk("hold_start_cout", cout, 0);
    d0 = done_cnt;
    run_op("midstart", 8'hA5, 8'h3C, 1, 8'hE2, 0, 1);
    repeat (12) @(negedge clk);
    chk("midstart_dones", done_cnt - d0, 1);
    chk("midstart_sum_held", sum, 8'hE2);
    @(negedge clk); a = 8'h12; b = 8'h34; cin = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_fa", {fa_a, fa_b, fa_cin}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    run_op("post_rst", 8'h12, 8'h34, 0, 8'h46, 0, 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial sequencer that drives one external full_adder instance, LSB first, one bit per clock, to add two WIDTH-bit operands plus carry-in.
- Sits directly upstream of the full adder: it supplies the adder's A/B/Cin inputs and consumes its S/Cout outputs.
- Assembles the serial sum into a parallel result with a start/busy/done handshake for board-level training designs.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse or level, sampled only in IDLE
- a  input  WIDTH  operand A, captured on start
- b  input  WIDTH  operand B, captured on start
- cin  input  1  initial carry-in, captured on start
- fa_a  output  1  to full adder input A
- fa_b  output  1  to full adder input B
- fa_cin  output  1  to full adder carry-in
- fa_s  input  1  full adder sum output
- fa_cout  input  1  full adder carry output
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held with sum

Behaviour:
- Reset: asynchronous on rst_n low. State returns to IDLE. All shift registers, carry register, counter, sum, cout and done are cleared to 0.
- One clock domain. No internal synchroniser on start.
- States:
  - IDLE: busy=0, done=0. fa_a, fa_b and fa_cin are driven 0.
  - On a rising edge with start=1: load a_sr=a, b_sr=b, carry_q=cin, cnt=0, then go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT: busy=1. Adder drive is combinational from registers only: fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry_q. Each edge:
  - s_sr shifts right with fa_s entering the MSB.
  - carry_q <= fa_cout.
  - a_sr and b_sr shift right with 0 fill.
  - cnt increments.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift): go to DONE. On that same edge, sum <= final s_sr including this bit, cout <= fa_cout, done <= 1.
- DONE: busy=1, done=1 for exactly one cycle. The next edge unconditionally goes to IDLE and done <= 0.
- Latency: start sampled at edge k, done high during the cycle following edge k+1+WIDTH-1, i.e. done rises WIDTH+1 edges after the start edge counted inclusively. For WIDTH=8, done is visible 9 edges after start is sampled.
- Back-to-back: the minimum issue interval is WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored. No queuing, and captured operands are unaffected.
- Changes on a, b and cin after capture have no effect.
- sum and cout change only on the transition into DONE. They hold their values across IDLE and the next operation until that operation completes.
- Reset mid-operation aborts immediately. done is not produced, and sum/cout read 0 after reset.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout. {cout,sum} = a + b + cin.
- cnt width is $clog2(WIDTH). There is no wrap beyond WIDTH-1.

Test Plan:
- WIDTH=8, a=0x3C, b=0x55, cin=0, start one cycle -> busy high for 9 cycles, single done pulse, sum=0x91, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; the earlier result is held until the second done.
- Hold start high for 20 cycles with a=0x0F, b=0x01 -> two operations. The second starts on the first IDLE edge after DONE. Each yields sum=0x10, cout=0, with exactly one done per operation.
- Pulse start again mid-SHIFT with different operands and change a/b during SHIFT -> result reflects only the originally captured operands; no extra done.
- Deassert rst_n asynchronously at shift cycle 4 -> busy, done, sum, cout and fa_* go to 0 immediately. A subsequent normal start of 0x12+0x34 gives 0x46.
- Check fa_a, fa_b and fa_cin each SHIFT cycle against the LSB-first bits of a, b and the running carry using a reference full-adder model. Verify these are 0 in IDLE.
